dot_product_ctrl: RTL and testbench

//  Sequencer that owns both ports of the shared true-dual-port vector RAM.

---
 rtl/dot_product_ctrl_if.sv | 62 ++++++
 rtl/dot_product_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_dot_product_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dot_product_ctrl_if.sv
// -----------------------------------------------------------------------------
// dot_product_ctrl_if
//   Bundles every non-clock/reset signal of the dot-product sequencer: the
//   load port, the start/config inputs, the result handshake and both RAM
//   ports.
//   slave  : seen by dot_product_ctrl (loads/starts arrive, RAM is driven)
//   master : seen by the environment (front-end, consumer and RAM model)
// Signals
//   ld_valid/ld_addr/ld_data/ld_ready    load word handshake
//   start/len/base_a/base_b/wb_addr      run request and configuration
//   busy/res_valid/res_ready/result      status and result handshake
//   ram_we_*/ram_w_addr_*/ram_din_*      RAM write ports a and b
//   ram_r_addr_*/ram_dout_*              RAM read ports a and b (1-cycle data)
// -----------------------------------------------------------------------------
interface dot_product_ctrl_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int ACC_WIDTH  = 2*WIDTH+ADDR_WIDTH
);
  logic                  ld_valid;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [WIDTH-1:0]      ld_data;
  logic                  ld_ready;

  logic                  start;
  logic [ADDR_WIDTH:0]   len;
  logic [ADDR_WIDTH-1:0] base_a;
  logic [ADDR_WIDTH-1:0] base_b;
  logic [ADDR_WIDTH-1:0] wb_addr;

  logic                  busy;
  logic                  res_valid;
  logic                  res_ready;
  logic [ACC_WIDTH-1:0]  result;

  logic                  ram_we_a;
  logic                  ram_we_b;
  logic [ADDR_WIDTH-1:0] ram_w_addr_a;
  logic [ADDR_WIDTH-1:0] ram_w_addr_b;
  logic [WIDTH-1:0]      ram_din_a;
  logic [WIDTH-1:0]      ram_din_b;
  logic [ADDR_WIDTH-1:0] ram_r_addr_a;
  logic [ADDR_WIDTH-1:0] ram_r_addr_b;
  logic [WIDTH-1:0]      ram_dout_a;
  logic [WIDTH-1:0]      ram_dout_b;

  modport slave (
    input  ld_valid, ld_addr, ld_data, start, len, base_a, base_b, wb_addr,
           res_ready, ram_dout_a, ram_dout_b,
    output ld_ready, busy, res_valid, result,
           ram_we_a, ram_we_b, ram_w_addr_a, ram_w_addr_b, ram_din_a, ram_din_b,
           ram_r_addr_a, ram_r_addr_b
  );

  modport master (
    output ld_valid, ld_addr, ld_data, start, len, base_a, base_b, wb_addr,
           res_ready, ram_dout_a, ram_dout_b,
    input  ld_ready, busy, res_valid, result,
           ram_we_a, ram_we_b, ram_w_addr_a, ram_w_addr_b, ram_din_a, ram_din_b,
           ram_r_addr_a, ram_r_addr_b
  );
endinterface

// File: rtl/dot_product_ctrl.sv
// -----------------------------------------------------------------------------
// dot_product_ctrl
//   Owns both ports of a true-dual-port vector RAM. In IDLE it forwards load
//   words to port a; on start it streams A[base_a+i] (port a) and B[base_b+i]
//   (port b) and multiply-accumulates them into the dot product.
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : dot_product_ctrl_if.slave (load, start/config, result, RAM ports)
// Configuration macro
//   DOTP_WRITEBACK_EN : adds a WB state writing the result, saturated to
//                       WIDTH bits, to RAM[wb_addr] through port b.
// -----------------------------------------------------------------------------
module dot_product_ctrl #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8,
  parameter int ACC_WIDTH  = 2*WIDTH+ADDR_WIDTH
) (
  input logic                clk,
  input logic                rst_n,
  dot_product_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
`ifdef DOTP_WRITEBACK_EN
    ST_WB,
`endif
    ST_DONE
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH:0]   idx_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH-1:0] r_addr_a_q;
  logic [ADDR_WIDTH-1:0] r_addr_b_q;
  logic                  dv_q;        // RAM data on dout belongs to this run
  logic [ACC_WIDTH-1:0]  acc_q;
  logic [ACC_WIDTH-1:0]  result_q;
  logic                  res_valid_q;
  logic                  busy_q;

  logic [ADDR_WIDTH:0]   len_clamp_d;
  logic [2*WIDTH-1:0]    prod_d;
  logic [ACC_WIDTH-1:0]  acc_sum_d;
  logic                  ld_fire_d;

  // Wrap an address into [0, DEPTH) so non-power-of-2 depths wrap correctly.
  function automatic logic [ADDR_WIDTH-1:0] wrap_addr(input logic [ADDR_WIDTH-1:0] a);
    return ADDR_WIDTH'(int'(a) % DEPTH);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] incr_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_WIDTH'(DEPTH-1)) ? '0 : a + 1'b1;
  endfunction

  assign len_clamp_d = (bus.len > (ADDR_WIDTH+1)'(DEPTH)) ? (ADDR_WIDTH+1)'(DEPTH) : bus.len;
  assign prod_d      = (2*WIDTH)'(bus.ram_dout_a) * (2*WIDTH)'(bus.ram_dout_b);
  assign acc_sum_d   = acc_q + ACC_WIDTH'(prod_d);

  // Load path is combinational so a word is written on the accepting edge.
  assign bus.ld_ready     = (state_q == ST_IDLE) && !bus.start;
  assign ld_fire_d        = bus.ld_valid && bus.ld_ready;
  assign bus.ram_we_a     = ld_fire_d;
  assign bus.ram_w_addr_a = ld_fire_d ? bus.ld_addr : '0;
  assign bus.ram_din_a    = ld_fire_d ? bus.ld_data : '0;

  assign bus.ram_r_addr_a = r_addr_a_q;
  assign bus.ram_r_addr_b = r_addr_b_q;
  assign bus.busy         = busy_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.result       = result_q;

`ifdef DOTP_WRITEBACK_EN
  logic [ADDR_WIDTH-1:0] wb_addr_q;
  logic                  we_b_q;
  logic [ADDR_WIDTH-1:0] w_addr_b_q;
  logic [WIDTH-1:0]      din_b_q;
  logic [WIDTH-1:0]      sat_d;

  assign sat_d            = (|acc_sum_d[ACC_WIDTH-1:WIDTH]) ? '1 : acc_sum_d[WIDTH-1:0];
  assign bus.ram_we_b     = we_b_q;
  assign bus.ram_w_addr_b = w_addr_b_q;
  assign bus.ram_din_b    = din_b_q;
`else
  assign bus.ram_we_b     = 1'b0;
  assign bus.ram_w_addr_b = '0;
  assign bus.ram_din_b    = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      r_addr_a_q  <= '0;
      r_addr_b_q  <= '0;
      dv_q        <= 1'b0;
      acc_q       <= '0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef DOTP_WRITEBACK_EN
      wb_addr_q   <= '0;
      we_b_q      <= 1'b0;
      w_addr_b_q  <= '0;
      din_b_q     <= '0;
`endif
    end else begin
      // Read data lags the issued address by one cycle.
      dv_q <= (state_q == ST_RUN);
      if (dv_q) acc_q <= acc_sum_d;

      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            len_q  <= len_clamp_d;
            idx_q  <= '0;
            acc_q  <= '0;
            busy_q <= 1'b1;
`ifdef DOTP_WRITEBACK_EN
            wb_addr_q <= bus.wb_addr;
`endif
            if (len_clamp_d == '0) begin
              result_q    <= '0;
              res_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              r_addr_a_q <= wrap_addr(bus.base_a);
              r_addr_b_q <= wrap_addr(bus.base_b);
              state_q    <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == len_q - 1'b1) begin
            r_addr_a_q <= '0;
            r_addr_b_q <= '0;
            state_q    <= ST_DRAIN;
          end else begin
            r_addr_a_q <= incr_addr(r_addr_a_q);
            r_addr_b_q <= incr_addr(r_addr_b_q);
          end
        end
        ST_DRAIN: begin
          // Last product is on dout this cycle.
          result_q <= acc_sum_d;
          idx_q    <= '0;
`ifdef DOTP_WRITEBACK_EN
          we_b_q     <= 1'b1;
          w_addr_b_q <= wb_addr_q;
          din_b_q    <= sat_d;
          state_q    <= ST_WB;
`else
          res_valid_q <= 1'b1;
          state_q     <= ST_DONE;
`endif
        end
`ifdef DOTP_WRITEBACK_EN
        ST_WB: begin
          we_b_q      <= 1'b0;
          w_addr_b_q  <= '0;
          din_b_q     <= '0;
          res_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
`endif
        ST_DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dot_product_ctrl
//   Directed bench for dot_product_ctrl with a behavioural dual-port RAM
//   (registered read, 1-cycle latency). Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_dot_product_ctrl;

  localparam int WIDTH      = 8;
  localparam int ADDR_WIDTH = 3;
  localparam int DEPTH      = 8;
  localparam int ACC_WIDTH  = 2*WIDTH+ADDR_WIDTH;
`ifdef DOTP_WRITEBACK_EN
  localparam int WB_EXTRA = 1;
`else
  localparam int WB_EXTRA = 0;
`endif

  logic clk;
  logic rst_n;

  dot_product_ctrl_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .ACC_WIDTH(ACC_WIDTH)) bus ();

  dot_product_ctrl #(
    .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .ACC_WIDTH(ACC_WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_we_a) mem[bus.ram_w_addr_a] <= bus.ram_din_a;
    if (bus.ram_we_b) mem[bus.ram_w_addr_b] <= bus.ram_din_b;
    bus.ram_dout_a <= mem[bus.ram_r_addr_a];
    bus.ram_dout_b <= mem[bus.ram_r_addr_b];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_word(input int a, input int d);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = ADDR_WIDTH'(a);
    bus.ld_data  = WIDTH'(d);
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
  endtask

  task automatic load_t1();
    for (int i = 0; i < 4; i++) load_word(i, i + 1);
    for (int i = 0; i < 4; i++) load_word(i + 4, i + 5);
  endtask

  task automatic start_op(input int ba, input int bb, input int ln, input int wb);
    bus.base_a  = ADDR_WIDTH'(ba);
    bus.base_b  = ADDR_WIDTH'(bb);
    bus.len     = (ADDR_WIDTH+1)'(ln);
    bus.wb_addr = ADDR_WIDTH'(wb);
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start   = 1'b0;
  endtask

  // lat counts the edge at which res_valid is first seen, start edge = 0.
  task automatic wait_res(input int lat0, output int lat);
    lat = lat0;
    while (!bus.res_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.res_valid) chk("res_valid_timeout", 0, 1);
    $display("run base_a=%0d base_b=%0d len=%0d -> result=%0d latency=%0d",
             bus.base_a, bus.base_b, bus.len, bus.result, lat);
  endtask

  task automatic ack();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  int lat;

  initial begin
    rst_n         = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_data   = '0;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.base_a    = '0;
    bus.base_b    = '0;
    bus.wb_addr   = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_busy", bus.busy, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_we_a", bus.ram_we_a, 0);
    chk("rst_we_b", bus.ram_we_b, 0);
    chk("rst_r_addr_a", bus.ram_r_addr_a, 0);
    chk("rst_r_addr_b", bus.ram_r_addr_b, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ld_ready", bus.ld_ready, 1);

    // Test 1: basic dot product 1*5+2*6+3*7+4*8 = 70
    load_t1();
    start_op(0, 4, 4, 7);
    chk("t1_busy", bus.busy, 1);
    wait_res(1, lat);
    chk("t1_latency", lat, 6 + WB_EXTRA);
    chk("t1_result", bus.result, 70);
    ack();
    chk("t1_res_valid_clr", bus.res_valid, 0);
    chk("t1_busy_clr", bus.busy, 0);
`ifdef DOTP_WRITEBACK_EN
    chk("t1_wb_mem", mem[7], 70);
`endif

    // Test 2: len=0, no reads issued, result 0 next cycle
    start_op(5, 3, 0, 0);
    chk("t2_r_addr_a", bus.ram_r_addr_a, 0);
    chk("t2_r_addr_b", bus.ram_r_addr_b, 0);
    wait_res(1, lat);
    chk("t2_latency", lat, 1);
    chk("t2_result", bus.result, 0);
    ack();

    // Test 5: hold res_ready low, start/load ignored
    load_word(7, 8);
    start_op(0, 4, 4, 7);
    wait_res(1, lat);
    for (int c = 0; c < 5; c++) begin
      bus.start    = 1'b1;
      bus.len      = 4'd2;
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 3'd0;
      bus.ld_data  = 8'd99;
      #1;
      chk("t5_ld_ready", bus.ld_ready, 0);
      chk("t5_we_a", bus.ram_we_a, 0);
      @(posedge clk); #1;
      chk("t5_result", bus.result, 70);
      chk("t5_res_valid", bus.res_valid, 1);
      chk("t5_busy", bus.busy, 1);
    end
    bus.start    = 1'b0;
    bus.ld_valid = 1'b0;
    ack();
    chk("t5_res_valid_clr", bus.res_valid, 0);
    chk("t5_busy_clr", bus.busy, 0);
    chk("t5_mem0_kept", mem[0], 1);

    // Test 6: async reset mid-RUN, then rerun
    load_word(7, 8);
    start_op(0, 4, 4, 7);
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("t6_pre_r_addr_b", bus.ram_r_addr_b, 6);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", bus.busy, 0);
    chk("t6_res_valid", bus.res_valid, 0);
    chk("t6_result", bus.result, 0);
    chk("t6_r_addr_a", bus.ram_r_addr_a, 0);
    chk("t6_r_addr_b", bus.ram_r_addr_b, 0);
    chk("t6_we_b", bus.ram_we_b, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_word(7, 8);
    start_op(0, 4, 4, 7);
    wait_res(1, lat);
    chk("t6_rerun_latency", lat, 6 + WB_EXTRA);
    chk("t6_rerun_result", bus.result, 70);
    ack();

    // Test 3: all 255, len=8 and clamped len=15 -> 8*65025 = 520200
    for (int i = 0; i < DEPTH; i++) load_word(i, 255);
    start_op(0, 0, 8, 0);
    wait_res(1, lat);
    chk("t3_latency", lat, 10 + WB_EXTRA);
    chk("t3_result", bus.result, 520200);
    ack();
`ifdef DOTP_WRITEBACK_EN
    chk("t3_wb_sat", mem[0], 255);
`endif
    start_op(0, 0, 15, 0);
    wait_res(1, lat);
    chk("t3_clamp_latency", lat, 10 + WB_EXTRA);
    chk("t3_clamp_result", bus.result, 520200);
    ack();

    // Test 4: wrap. mem[i]=2i+1; A@6,7,0,1=13,15,1,3; B@2..5=5,7,9,11 -> 212
    for (int i = 0; i < DEPTH; i++) load_word(i, 2*i + 1);
    start_op(6, 2, 4, 6);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_r_addr_a_%0d", i), bus.ram_r_addr_a, (6 + i) % 8);
      chk($sformatf("t4_r_addr_b_%0d", i), bus.ram_r_addr_b, 2 + i);
      @(posedge clk); #1;
    end
    wait_res(5, lat);
    chk("t4_latency", lat, 6 + WB_EXTRA);
    chk("t4_result", bus.result, 212);
    ack();
`ifdef DOTP_WRITEBACK_EN
    chk("t4_wb_mem", mem[6], 212);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
